fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Instruction fetch controller that sequences the word-indexed, asynchronous-read Instruction_Memory (32 x 32-bit).
- Owns the program counter and drives the memory address.
- Captures each returned instruction with its PC into a 2-entry fetch buffer and presents it to decode over a valid/ready handshake.
- Handles start, completion, decode backpressure and branch redirect with flush.

Parameters:
DATA_W, 32, instruction width; matches Instruction_Memory BITSIZE.
ADDR_W, 32, width of the address port into Instruction_Memory.
PC_W, 5, word-index width; the memory depth is 2**PC_W words.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  begin a program run; sampled only in IDLE or DONE.
prog_len  input  PC_W+1  number of instructions to fetch (0..2**PC_W); latched on an accepted start.
imem_addr  output  ADDR_W  word index to Instruction_Memory Address; equals the PC zero-extended.
imem_data  input  DATA_W  Instruction_Memory ReadData1; combinational in the same cycle.
redirect_valid  input  1  branch/jump redirect request from the execute stage.
redirect_pc  input  PC_W  redirect target, as a word index.
inst_valid  output  1  buffer head holds a valid instruction.
inst_ready  input  1  decode accepts the head this cycle.
inst_data  output  DATA_W  head instruction.
inst_pc  output  PC_W  word index of the head instruction.
busy  output  1  high in FETCH and DRAIN.
done  output  1  high in DONE.

Behaviour:
- Reset (synchronous): state=IDLE, pc=0, len=0, buffer count=0, entries cleared.
  - All outputs read 0: imem_addr=0, inst_valid=0, inst_data=0, inst_pc=0, busy=0, done=0.
  - Reset asserted mid-run discards all buffered entries the same edge; no instruction is delivered after it.
- States:
  - IDLE: start -> FETCH; pc<=0, len<=prog_len.
  - FETCH: while pc<len, fetch per the rules below. When pc==len -> DRAIN.
  - DRAIN: no fetch; count==0 -> DONE.
  - DONE: done=1 held; start -> FETCH (same actions as from IDLE).
- start is ignored in FETCH and DRAIN.
- Handshake and buffer:
  - pop = inst_valid & inst_ready.
  - inst_valid = (count!=0).
  - inst_data and inst_pc come from registered buffer storage; they are never combinational from imem_data.
  - Fetch enable = FETCH & pc<len & (count<2 | pop) & ~redirect_valid.
  - On fetch, push {pc, imem_data} at the tail and increment pc.
  - Push and pop in the same cycle leave count unchanged and preserve order.
  - inst_valid, inst_data and inst_pc stay stable while inst_valid=1 and inst_ready=0.
- Latency: start sampled at edge N -> FETCH after N -> first push at edge N+1 -> inst_valid=1 after N+1.
  - With inst_ready held high, throughput is 1 instruction per cycle.
- Redirect (FETCH or DRAIN only; ignored in IDLE and DONE):
  - Flush: count<=0, pc<=redirect_pc, no push that cycle.
  - A pop in the same cycle counts as accepted by decode; that entry is consumed, not replayed.
  - The state is re-evaluated next cycle: if redirect_pc>=len, FETCH moves to DRAIN, then DONE. A redirect in DRAIN with redirect_pc<len returns to FETCH.
- Width rules:
  - pc is PC_W+1 bits internally so that pc==len==2**PC_W is representable; it does not wrap.
  - imem_addr carries only pc[PC_W-1:0], zero-extended, and holds its last value in DRAIN and DONE.
- prog_len=0: FETCH for one cycle with no fetch -> DRAIN -> DONE. inst_valid is never asserted.

Test Plan:
- Straight run: prog_len=16, inst_ready=1, start pulse. inst_valid rises 2 edges after start. inst_pc runs 0..15 one per cycle and inst_data matches the memory words. done=1 after the last pop plus the DRAIN cycle.
- Backpressure: prog_len=16, inst_ready=0 after start. Buffer fills with pc 0,1; imem_addr holds 2; no pc advance. Releasing ready delivers 0,1,2,... with no loss or duplicate.
- Redirect flush: redirect_valid=1, redirect_pc=8 while the buffer holds pc 3,4 and ready=0. Next valid inst_pc=8; pc 3,4 are never delivered.
- Redirect with simultaneous pop: head pc=5 popped in the same cycle as redirect to 12. Decode receives 5, then 12; pc 6 is never delivered.
- Boundaries:
  - prog_len=0 -> done=1 three cycles after start, inst_valid never 1.
  - prog_len=32 -> pc 31 is delivered, then DONE with no wrap to 0.
- Reset mid-run: reset at the cycle after 3 instructions are delivered. Next cycle inst_valid=0, busy=0, imem_addr=0. A restart with start delivers from pc 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch controller for a word-indexed,
// asynchronous-read instruction memory. Owns the PC, drives the memory
// address, and captures each fetched word with its PC into a 2-entry
// buffer that decode drains over a valid/ready handshake.
module fetch_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int PC_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PC_W:0]     prog_len,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [PC_W-1:0]   inst_pc,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  // pc and len carry one extra bit so a full-depth program ends at 2**PC_W
  logic [PC_W:0]     pc, pc_nxt;
  logic [PC_W:0]     len, len_nxt;
  logic [1:0]        count;
  logic [DATA_W-1:0] buf_data [2];
  logic [PC_W-1:0]   buf_pc   [2];
  logic [PC_W-1:0]   addr_hold;
  logic [PC_W-1:0]   fetch_addr;
  logic [PC_W:0]     redirect_ext;
  logic              in_run;
  logic              flush;
  logic              pop;
  logic              fetch;

  assign in_run       = (state == FETCH) || (state == DRAIN);
  assign flush        = in_run && redirect_valid;
  assign pop          = inst_valid && inst_ready;
  assign redirect_ext = {1'b0, redirect_pc};
  // A full buffer can still accept a push when the head leaves this cycle
  assign fetch        = (state == FETCH) && (pc < len) &&
                        ((count != 2'd2) || pop) && !redirect_valid;

  // Address follows the PC only while actively fetching; otherwise it holds
  assign fetch_addr = ((state == FETCH) && (pc < len)) ? pc[PC_W-1:0] : addr_hold;
  assign imem_addr  = {{(ADDR_W-PC_W){1'b0}}, fetch_addr};

  assign inst_valid = (count != 2'd0);
  assign inst_data  = buf_data[0];
  assign inst_pc    = buf_pc[0];
  assign busy       = in_run;
  assign done       = (state == DONE);

  // Next-state, PC and length selection
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    len_nxt   = len;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = FETCH;
          pc_nxt    = '0;
          len_nxt   = prog_len;
        end
      end
      FETCH: begin
        if (redirect_valid) begin
          pc_nxt = redirect_ext;
        end else if (fetch) begin
          pc_nxt = pc + (PC_W+1)'(1);
        end else if (pc >= len) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_ext;
          state_nxt = (redirect_ext < len) ? FETCH : DRAIN;
        end else if (count == 2'd0) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers: state, PC, program length, held address
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= '0;
      len       <= '0;
      addr_hold <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      len       <= len_nxt;
      addr_hold <= fetch_addr;
    end
  end

  // Two-entry buffer kept head-aligned at index 0; flush drops all entries
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({fetch, pop})
        2'b10: begin
          if (count == 2'd0) begin
            buf_data[0] <= imem_data;
            buf_pc[0]   <= pc[PC_W-1:0];
          end else begin
            buf_data[1] <= imem_data;
            buf_pc[1]   <= pc[PC_W-1:0];
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          buf_data[0] <= buf_data[1];
          buf_pc[0]   <= buf_pc[1];
          count       <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            buf_data[0] <= imem_data;
            buf_pc[0]   <= pc[PC_W-1:0];
          end else begin
            buf_data[0] <= buf_data[1];
            buf_pc[0]   <= buf_pc[1];
            buf_data[1] <= imem_data;
            buf_pc[1]   <= pc[PC_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
